// File: rtl/seg_display_reader_if.sv
// Record stream from the segment-display reader: valid/ready handshake
// carrying one decoded display frame per transfer.
interface seg_display_reader_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_err;

    // Producer side (the reader drives records, consumer drives ready)
    modport master (
        output out_valid,
        output out_digit,
        output out_blank,
        output out_err,
        input  out_ready
    );

    // Consumer side
    modport slave (
        input  out_valid,
        input  out_digit,
        input  out_blank,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/seg_display_reader.sv
// Seven-segment stream reader: waits for a segment pattern to hold steady for
// STABLE_CYCLES edges, decodes it once into a hex/blank/error record and queues
// the record in a small first-word-fall-through FIFO with a registered head.
module seg_display_reader #(
    parameter int STABLE_CYCLES = 1000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [6:0]           seg_in,
    output logic                 overflow,
    seg_display_reader_if.master out_if
);

    localparam int CW   = $clog2(STABLE_CYCLES);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] CNT_PUSH = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    // Segment codes {g,f,e,d,c,b,a} indexed by the hex value they display
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [6:0]    seg_q, seg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reported_q, reported_d;
    logic          overflow_q, overflow_d;

    // Record layout: {err, blank, digit}
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;     // entries in mem, excluding the head register
    logic          out_valid_q, out_valid_d;
    logic [5:0]    out_rec_q, out_rec_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [15:0] hit;
    logic [3:0]  dec_digit;
    logic        dec_blank;
    logic        dec_err;
    logic [5:0]  rec_in;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (seg_in == SEG_CODE[gi]);
        end
    endgenerate

    // Table codes are unique, so OR-ing the indices of the matches yields the value
    always_comb begin
        dec_digit = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                dec_digit = dec_digit | 4'(i);
            end
        end
        dec_blank = (seg_in == 7'h00);
        dec_err   = ~(|hit) & ~dec_blank;
        rec_in    = {dec_err, dec_blank, dec_digit};
    end

    // ------------------------------------------------------------------
    // Stability tracking and push request
    // ------------------------------------------------------------------
    logic same;
    logic push_req;

    // Run counter: restarts on any pattern change or while observation is off;
    // reported latches so a long run yields exactly one record
    always_comb begin
        seg_d      = seg_in;
        cnt_d      = cnt_q;
        reported_d = reported_q;
        same       = (seg_in == seg_q);
        push_req   = ena & same & (cnt_q == CNT_PUSH) & ~reported_q;
        if (!ena || !same) begin
            cnt_d      = '0;
            reported_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (push_req) begin
                reported_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic          pop;
    logic [NW-1:0] total;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic          load;

    // Capacity counts the head register too, so FIFO_DEPTH records fit in total.
    // The head reloads from storage whenever it is empty or being consumed.
    always_comb begin
        pop     = out_valid_q & out_if.out_ready;
        total   = count_q + NW'(out_valid_q);
        full    = (total == DEPTH_N);
        push_ok = push_req & (~full | pop);
        drop    = push_req & full & ~pop;
        load    = (~out_valid_q | pop) & (count_q != '0);

        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(load);
        count_d    = count_q + NW'(push_ok) - NW'(load);
        overflow_d = overflow_q | drop;

        out_valid_d = out_valid_q;
        out_rec_d   = out_rec_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_rec_d   = mem[rd_ptr_q];
        end else if (pop) begin
            out_valid_d = 1'b0;
            out_rec_d   = '0;
        end
    end

    // Record storage: plain write port, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= rec_in;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= '0;
            cnt_q       <= '0;
            reported_q  <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_rec_q   <= '0;
        end else begin
            seg_q       <= seg_d;
            cnt_q       <= cnt_d;
            reported_q  <= reported_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_rec_q   <= out_rec_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_digit = out_rec_q[3:0];
    assign out_if.out_blank = out_rec_q[4];
    assign out_if.out_err   = out_rec_q[5];
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader: stable-run detection, glitch rejection,
// decode of digit/blank/error frames, FIFO overflow and mid-run reset.
module tb_seg_display_reader;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [6:0] seg_in;
    logic       overflow;

    int checks;
    int passed;

    logic [5:0] rec_log [$];   // {err, blank, digit} of every accepted record

    seg_display_reader_if bus ();

    seg_display_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .seg_in   (seg_in),
        .overflow (overflow),
        .out_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log each handshake; values are steady between edges so negedge is safe
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            rec_log.push_back({bus.out_err, bus.out_blank, bus.out_digit});
            $display("rec %0d: digit=%h blank=%b err=%b", rec_log.size(),
                     bus.out_digit, bus.out_blank, bus.out_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [6:0] seg, input int n);
        seg_in = seg;
        tick(n);
    endtask

    function automatic logic [5:0] log_at(input int idx);
        if (idx < rec_log.size()) return rec_log[idx];
        return 6'h3F;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; seg_in = 7'h00; bus.out_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_digit !== 4'h0) $display("FAIL reset_digit got %h want 0", bus.out_digit); else passed++;
        checks++; if ({bus.out_blank, bus.out_err} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.out_blank, bus.out_err}); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
    endtask

    task automatic test_single_digit();
        rec_log.delete();
        seg_in = 7'h06;
        for (int i = 1; i <= 1001; i++) begin
            tick(1);
            if (i == 1000) begin
                checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", bus.out_valid); else passed++;
            end
        end
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if ({bus.out_err, bus.out_blank, bus.out_digit} !== 6'h01) $display("FAIL single_rec got %h want 01", {bus.out_err, bus.out_blank, bus.out_digit}); else passed++;
        bus.out_ready = 1'b1;
        tick(499);
        checks++; if (rec_log.size() !== 1) $display("FAIL single_count got %0d want 1", rec_log.size()); else passed++;
        checks++; if (log_at(0) !== 6'h01) $display("FAIL single_logged got %h want 01", log_at(0)); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_drained got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_glitch();
        rec_log.delete();
        hold(7'h4F, 999);
        hold(7'h00, 999);
        checks++; if (rec_log.size() !== 0) $display("FAIL glitch_none got %0d want 0", rec_log.size()); else passed++;
        tick(3);
        checks++; if (rec_log.size() !== 1) $display("FAIL glitch_blank_count got %0d want 1", rec_log.size()); else passed++;
        checks++; if (log_at(0) !== 6'h10) $display("FAIL glitch_blank_rec got %h want 10", log_at(0)); else passed++;
    endtask

    task automatic test_sequence();
        logic [6:0] pat [5];
        logic [5:0] exp [5];
        pat = '{7'h5B, 7'h00, 7'h6D, 7'h00, 7'h7F};
        exp = '{6'h02, 6'h10, 6'h05, 6'h10, 6'h08};
        rec_log.delete();
        for (int i = 0; i < 5; i++) hold(pat[i], 1000);
        tick(5);
        checks++; if (rec_log.size() !== 5) $display("FAIL seq_count got %0d want 5", rec_log.size()); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (log_at(i) !== exp[i]) $display("FAIL seq_rec%0d got %h want %h", i, log_at(i), exp[i]); else passed++;
        end
    endtask

    task automatic test_error_pattern();
        rec_log.delete();
        hold(7'h12, 5000);
        checks++; if (rec_log.size() !== 1) $display("FAIL err_count got %0d want 1", rec_log.size()); else passed++;
        checks++; if (log_at(0) !== 6'h20) $display("FAIL err_rec got %h want 20", log_at(0)); else passed++;
    endtask

    task automatic test_ena();
        rec_log.delete();
        ena = 1'b0;
        hold(7'h07, 1500);
        checks++; if (rec_log.size() !== 0) $display("FAIL ena_off_count got %0d want 0", rec_log.size()); else passed++;
        ena = 1'b1;
        tick(1002);
        checks++; if (rec_log.size() !== 1) $display("FAIL ena_on_count got %0d want 1", rec_log.size()); else passed++;
        checks++; if (log_at(0) !== 6'h07) $display("FAIL ena_on_rec got %h want 07", log_at(0)); else passed++;
    endtask

    task automatic test_overflow();
        logic [6:0] pat [6];
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
        bus.out_ready = 1'b0;
        rec_log.delete();
        for (int i = 0; i < 6; i++) hold(pat[i], 1000);
        tick(5);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL ovf_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if (bus.out_digit !== 4'h0) $display("FAIL ovf_head got %h want 0", bus.out_digit); else passed++;
        bus.out_ready = 1'b1;
        tick(6);
        checks++; if (rec_log.size() !== 4) $display("FAIL ovf_count got %0d want 4", rec_log.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (log_at(i) !== 6'(i)) $display("FAIL ovf_rec%0d got %h want %h", i, log_at(i), 6'(i)); else passed++;
        end
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", bus.out_valid); else passed++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else passed++;
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        rec_log.delete();
        hold(7'h06, 1000);
        hold(7'h5B, 1000);
        hold(7'h4F, 1000);
        hold(7'h66, 500);
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL mrst_pre_valid got %b want 1", bus.out_valid); else passed++;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL mrst_overflow got %b want 0", overflow); else passed++;
        for (int i = 1; i <= 1001; i++) begin
            tick(1);
            if (i == 1000) begin
                checks++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_early_valid got %b want 0", bus.out_valid); else passed++;
            end
        end
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL mrst_late_valid got %b want 1", bus.out_valid); else passed++;
        checks++; if ({bus.out_err, bus.out_blank, bus.out_digit} !== 6'h04) $display("FAIL mrst_rec got %h want 04", {bus.out_err, bus.out_blank, bus.out_digit}); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_single_digit();
        test_glitch();
        test_sequence();
        test_error_pattern();
        test_ena();
        test_overflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
